// File: rtl/sprite_compositor_pkg.sv
// Shared video constants, display modes and the pixel colour payload for the Pong video path.
package sprite_compositor_pkg;

    localparam int unsigned H_VIDEO = 640;
    localparam int unsigned V_VIDEO = 480;

    typedef enum logic [1:0] {
        MODE_GAME      = 2'd0,
        MODE_STARTUP   = 2'd1,
        MODE_GAME_OVER = 2'd2,
        MODE_BLANK     = 2'd3
    } mode_e;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t WHITE = '{r: 1'b1, g: 1'b1, b: 1'b1};
    localparam rgb_t BLACK = '{r: 1'b0, g: 1'b0, b: 1'b0};

endpackage

// File: rtl/sprite_compositor_hit_test.sv
// Per-sprite stage-1 hit test against attributes shadowed at the frame boundary.
module sprite_compositor_hit_test #(
    parameter int unsigned COORD_W = 10
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic               capture,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [COORD_W-1:0] spr_w,
    input  logic [COORD_W-1:0] spr_h,
    input  logic               spr_en,
    input  logic               spr_blink,
    input  logic               blink_on,
    output logic               hit
);

    logic [COORD_W-1:0] x_q, y_q, w_q, h_q;
    logic               en_q, blink_q;
    logic [COORD_W:0]   x_end_c, y_end_c;
    logic               in_rect_c;

    // Extra bit on the far edges keeps sprites touching the coordinate limit from wrapping.
    assign x_end_c   = {1'b0, x_q} + {1'b0, w_q};
    assign y_end_c   = {1'b0, y_q} + {1'b0, h_q};
    assign in_rect_c = (pixel_x >= x_q) && ({1'b0, pixel_x} < x_end_c)
                    && (pixel_y >= y_q) && ({1'b0, pixel_y} < y_end_c);

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            en_q    <= 1'b0;
            blink_q <= 1'b0;
            hit     <= 1'b0;
        end else begin
            if (capture) begin
                x_q     <= spr_x;
                y_q     <= spr_y;
                w_q     <= spr_w;
                h_q     <= spr_h;
                en_q    <= spr_en;
                blink_q <= spr_blink;
            end
            hit <= in_rect_c && en_q && (!blink_q || blink_on);
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite pixel compositor: frame-shadowed attributes, blink and net counters, 2-stage pipeline to RGB.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int unsigned NUM_SPRITES  = 4,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned H_VIDEO_P    = H_VIDEO,
    parameter int unsigned V_VIDEO_P    = V_VIDEO,
    parameter int unsigned NET_WIDTH    = 12,
    parameter int unsigned NET_PERIOD   = 24,
    parameter int unsigned NET_ON       = 12,
    parameter int unsigned NET_PHASE    = 18,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter logic [2:0]  BG_COLOR     = 3'b000
) (
    input  logic                           clk_0,
    input  logic                           rst,
    input  logic [COORD_W-1:0]             pixel_x,
    input  logic [COORD_W-1:0]             pixel_y,
    input  logic                           video_on,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_x,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_y,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_w,
    input  logic [NUM_SPRITES*COORD_W-1:0] spr_h,
    input  logic [NUM_SPRITES-1:0]         spr_en,
    input  logic [NUM_SPRITES-1:0]         spr_blink,
    input  logic [NUM_SPRITES*3-1:0]       spr_color,
    input  logic                           net_en,
    input  logic                           score_pixel,
    input  logic                           text_pixel,
    input  logic [1:0]                     mode,
    output logic                           frame_start,
    output logic                           red,
    output logic                           green,
    output logic                           blue
);

    localparam int unsigned BLINK_W = $clog2(2 * BLINK_FRAMES);
    localparam int unsigned NET_W   = $clog2(NET_PERIOD);
    localparam int unsigned NET_LO  = H_VIDEO_P / 2 - NET_WIDTH / 2;
    localparam int unsigned NET_HI  = H_VIDEO_P / 2 + NET_WIDTH / 2 - 1;

    logic                     boundary_c, origin_c, blink_on_c, net_hit_c;
    logic [BLINK_W-1:0]       blink_cnt;
    logic [NET_W-1:0]         net_cnt;
    logic [NUM_SPRITES*3-1:0] color_q;
    mode_e                    mode_q;
    logic                     net_en_q;
    logic [NUM_SPRITES-1:0]   hit_s1;
    logic                     net_s1, score_s1, text_s1, video_s1;
    rgb_t                     pix_c;

    assign boundary_c = (pixel_x == '0) && (pixel_y == COORD_W'(V_VIDEO_P));
    assign origin_c   = (pixel_x == '0) && (pixel_y == '0);
    assign blink_on_c = blink_cnt < BLINK_W'(BLINK_FRAMES);
    assign net_hit_c  = (net_cnt < NET_W'(NET_ON))
                     && (pixel_x >= COORD_W'(NET_LO)) && (pixel_x <= COORD_W'(NET_HI));

    // Frame-level state: boundary pulse, blink phase and shadowed global attributes.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            frame_start <= 1'b0;
            blink_cnt   <= '0;
            color_q     <= '0;
            mode_q      <= MODE_BLANK;
            net_en_q    <= 1'b0;
        end else begin
            frame_start <= boundary_c;
            if (boundary_c) begin
                blink_cnt <= (blink_cnt == BLINK_W'(2 * BLINK_FRAMES - 1)) ? '0
                                                                           : blink_cnt + BLINK_W'(1);
                color_q   <= spr_color;
                mode_q    <= mode_e'(mode);
                net_en_q  <= net_en;
            end
        end
    end

    // Dash phase of the centre net, one step per active line.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            net_cnt <= '0;
        end else if (origin_c) begin
            net_cnt <= NET_W'(NET_PHASE);
        end else if ((pixel_x == '0) && video_on) begin
            net_cnt <= (net_cnt == NET_W'(NET_PERIOD - 1)) ? '0 : net_cnt + NET_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
        sprite_compositor_hit_test #(
            .COORD_W (COORD_W)
        ) u_hit (
            .clk_0     (clk_0),
            .rst       (rst),
            .capture   (boundary_c),
            .pixel_x   (pixel_x),
            .pixel_y   (pixel_y),
            .spr_x     (spr_x[g*COORD_W +: COORD_W]),
            .spr_y     (spr_y[g*COORD_W +: COORD_W]),
            .spr_w     (spr_w[g*COORD_W +: COORD_W]),
            .spr_h     (spr_h[g*COORD_W +: COORD_W]),
            .spr_en    (spr_en[g]),
            .spr_blink (spr_blink[g]),
            .blink_on  (blink_on_c),
            .hit       (hit_s1[g])
        );
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            net_s1   <= 1'b0;
            score_s1 <= 1'b0;
            text_s1  <= 1'b0;
            video_s1 <= 1'b0;
        end else begin
            net_s1   <= net_hit_c;
            score_s1 <= score_pixel;
            text_s1  <= text_pixel;
            video_s1 <= video_on;
        end
    end

    // Stage-2 priority: later assignments win, so sprite 0 is applied last.
    always_comb begin
        pix_c = rgb_t'(BG_COLOR);
        if (!video_s1) begin
            pix_c = BLACK;
        end else begin
            case (mode_q)
                MODE_STARTUP, MODE_GAME_OVER: pix_c = text_s1 ? WHITE : rgb_t'(BG_COLOR);
                MODE_GAME: begin
                    if (net_s1 && net_en_q) pix_c = WHITE;
                    if (score_s1)           pix_c = WHITE;
                    for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
                        if (hit_s1[i]) pix_c = rgb_t'(color_q[i*3 +: 3]);
                    end
                end
                default: pix_c = rgb_t'(BG_COLOR);
            endcase
        end
    end

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else begin
            red   <= pix_c.r;
            green <= pix_c.g;
            blue  <= pix_c.b;
        end
    end

endmodule
